// File: rtl/pong_match_controller_pkg.sv
// pong_match_controller_pkg: shared encodings, geometry and helpers for the Pong match logic.
package pong_match_controller_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1 = 2'b01;
  localparam logic [1:0] WIN_P2 = 2'b10;
  localparam int PADDLE_WIDTH = 8;
  localparam int PADDLE_HEIGHT = 64;
  localparam int PADDLE_X_LEFT = 16;
  localparam int PADDLE_X_RIGHT = 616;
  localparam int BALL_SIZE = 8;
  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    return v >= lim ? lim : v + 4'd1;
  endfunction
endpackage

// File: rtl/pong_match_controller_edge_sync.sv
// edge_sync: optional 2-FF synchronizer followed by a registered rising-edge pulse.
module edge_sync #(
  parameter bit SYNC = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);
  logic s1, s2, prev, lvl;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  assign lvl = SYNC ? s2 : d;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      prev  <= lvl;
      pulse <= lvl & ~prev;
    end
endmodule

// File: rtl/pong_match_controller.sv
// pong_match_controller: match sequencer that holds, re-centres and releases the ball, scores misses and declares a winner.
module pong_match_controller
  import pong_match_controller_pkg::*;
#(
  parameter int WIN_SCORE = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       endofframe,
  input  logic       start_btn,
  input  logic       miss_left,
  input  logic       miss_right,
  input  logic       hit,
  output logic       ball_hold,
  output logic       ball_recentre,
  output logic       serve_dir,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [1:0] winner,
  output logic [2:0] state,
  output logic       beep
);
  localparam logic [3:0] WIN = 4'(WIN_SCORE);
  localparam logic [7:0] SF = 8'(SERVE_FRAMES);
  localparam logic [7:0] PF = 8'(POINT_FRAMES);
  state_t st;
  logic [7:0] cnt;
  logic frame_tick, start_pulse, last;
  edge_sync #(.SYNC(1'b1)) u_start (.clk(clk), .reset(reset), .d(start_btn), .pulse(start_pulse));
  edge_sync #(.SYNC(1'b0)) u_frame (.clk(clk), .reset(reset), .d(endofframe), .pulse(frame_tick));
  assign state = st;
  assign last = cnt <= 8'd1;
  // One shared countdown: SERVE and POINT each reload it on entry.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st            <= IDLE;
      ball_hold     <= 1'b1;
      ball_recentre <= 1'b0;
      serve_dir     <= 1'b0;
      score_p1      <= 4'd0;
      score_p2      <= 4'd0;
      winner        <= WIN_NONE;
      cnt           <= 8'd0;
      beep          <= 1'b0;
    end else begin
      ball_recentre <= 1'b0;
      beep          <= 1'b0;
      case (st)
        IDLE: begin
          ball_hold <= 1'b1;
          if (start_pulse) begin
            st            <= SERVE;
            score_p1      <= 4'd0;
            score_p2      <= 4'd0;
            winner        <= WIN_NONE;
            ball_recentre <= 1'b1;
            cnt           <= SF;
          end
        end
        SERVE: if (frame_tick) begin
          cnt <= cnt - 8'd1;
          if (last) begin
            st        <= PLAY;
            ball_hold <= 1'b0;
          end
        end
        PLAY: if (frame_tick) begin
          if (miss_left || miss_right) begin
            st        <= POINT;
            ball_hold <= 1'b1;
            cnt       <= PF;
            beep      <= 1'b1;
            // Serve goes toward whoever just lost the point; a double miss scores nobody.
            if (miss_right && !miss_left) begin
              score_p1  <= sat_inc(score_p1, WIN);
              serve_dir <= 1'b1;
            end
            if (miss_left && !miss_right) begin
              score_p2  <= sat_inc(score_p2, WIN);
              serve_dir <= 1'b0;
            end
          end else if (hit) begin
            beep <= 1'b1;
          end
        end
        POINT: if (frame_tick) begin
          cnt <= cnt - 8'd1;
          if (last) begin
            if (score_p1 == WIN || score_p2 == WIN) begin
              st     <= OVER;
              winner <= score_p1 == WIN ? WIN_P1 : WIN_P2;
            end else begin
              st            <= SERVE;
              ball_recentre <= 1'b1;
              cnt           <= SF;
            end
          end
        end
        OVER: if (start_pulse) st <= IDLE;
        default: begin
          st        <= IDLE;
          ball_hold <= 1'b1;
        end
      endcase
    end
endmodule

// File: tb/tb_pong_match_controller.sv
// tb_pong_match_controller: table-driven match sequencing with a scoreboard queue of expected outputs.
module tb_pong_match_controller;
  import pong_match_controller_pkg::*;
  typedef struct packed {
    logic [2:0] st;
    logic       hold;
    logic       rc;
    logic       sdir;
    logic [3:0] p1;
    logic [3:0] p2;
    logic [1:0] win;
    logic       bp;
  } exp_t;
  typedef enum int {K_TICK, K_GAP, K_START, K_RUN} kind_t;
  typedef struct {
    kind_t k;
    int    n;
    logic  ml;
    logic  mr;
    logic  h;
    exp_t  e;
  } row_t;
  logic clk, reset, endofframe, start_btn, miss_left, miss_right, hit;
  logic ball_hold, ball_recentre, serve_dir, beep;
  logic [3:0] score_p1, score_p2;
  logic [1:0] winner;
  logic [2:0] state;
  int n_cmp, n_bad;
  exp_t sb_q[$];
  row_t tbl[$];
  exp_t cur, idle_e;
  row_t r;
  pong_match_controller #(.WIN_SCORE(3), .SERVE_FRAMES(60), .POINT_FRAMES(90)) dut (
    .clk(clk), .reset(reset), .endofframe(endofframe), .start_btn(start_btn),
    .miss_left(miss_left), .miss_right(miss_right), .hit(hit),
    .ball_hold(ball_hold), .ball_recentre(ball_recentre), .serve_dir(serve_dir),
    .score_p1(score_p1), .score_p2(score_p2), .winner(winner), .state(state), .beep(beep)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic exp_t mk(int st, int hold, int rc, int sdir, int p1, int p2, int win, int bp);
    return {3'(st), 1'(hold), 1'(rc), 1'(sdir), 4'(p1), 4'(p2), 2'(win), 1'(bp)};
  endfunction
  task automatic add(kind_t k, int n, logic ml, logic mr, logic h, exp_t e);
    row_t x;
    x.k = k;
    x.n = n;
    x.ml = ml;
    x.mr = mr;
    x.h = h;
    x.e = e;
    tbl.push_back(x);
  endtask
  task automatic check(string name);
    exp_t got, want;
    got = {state, ball_hold, ball_recentre, serve_dir, score_p1, score_p2, winner, beep};
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty, got st=%0d", name, got.st);
    end else begin
      want = sb_q.pop_front();
      if (got !== want) begin
        n_bad++;
        $display("FAIL %s: got st=%0d hold=%b rc=%b dir=%b p1=%0d p2=%0d win=%b beep=%b, want st=%0d hold=%b rc=%b dir=%b p1=%0d p2=%0d win=%b beep=%b",
                 name, got.st, got.hold, got.rc, got.sdir, got.p1, got.p2, got.win, got.bp,
                 want.st, want.hold, want.rc, want.sdir, want.p1, want.p2, want.win, want.bp);
      end
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  // One frame: endofframe high for a cycle; misses/hit held across the edge that sees frame_tick.
  task automatic tick(logic ml, logic mr, logic h);
    @(posedge clk);
    #1 endofframe = 1'b1;
    miss_left = ml;
    miss_right = mr;
    hit = h;
    @(posedge clk);
    #1 endofframe = 1'b0;
    @(posedge clk);
    @(negedge clk);
    miss_left = 1'b0;
    miss_right = 1'b0;
    hit = 1'b0;
  endtask
  task automatic gap(logic ml, logic mr, logic h);
    @(posedge clk);
    #1 miss_left = ml;
    miss_right = mr;
    hit = h;
    repeat (3) @(posedge clk);
    @(negedge clk);
    miss_left = 1'b0;
    miss_right = 1'b0;
    hit = 1'b0;
  endtask
  // Ends three edges after the press; the state register updates on the next edge.
  task automatic press();
    @(posedge clk);
    #1 start_btn = 1'b1;
    @(posedge clk);
    #1 start_btn = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    endofframe = 1'b0;
    start_btn = 1'b0;
    miss_left = 1'b0;
    miss_right = 1'b0;
    hit = 1'b0;
    add(K_RUN, 60, 0, 0, 0, mk(PLAY, 0, 0, 0, 0, 0, 0, 0));
    add(K_TICK, 0, 0, 0, 1, mk(PLAY, 0, 0, 0, 0, 0, 0, 1));
    add(K_GAP, 0, 1, 0, 0, mk(PLAY, 0, 0, 0, 0, 0, 0, 0));
    add(K_START, 0, 0, 0, 0, mk(PLAY, 0, 0, 0, 0, 0, 0, 0));
    add(K_TICK, 0, 0, 0, 0, mk(PLAY, 0, 0, 0, 0, 0, 0, 0));
    add(K_TICK, 0, 0, 1, 0, mk(POINT, 1, 0, 1, 1, 0, 0, 1));
    add(K_RUN, 90, 0, 0, 0, mk(SERVE, 1, 1, 1, 1, 0, 0, 0));
    add(K_RUN, 60, 0, 0, 0, mk(PLAY, 0, 0, 1, 1, 0, 0, 0));
    add(K_TICK, 0, 1, 1, 0, mk(POINT, 1, 0, 1, 1, 0, 0, 1));
    add(K_RUN, 90, 0, 0, 0, mk(SERVE, 1, 1, 1, 1, 0, 0, 0));
    add(K_RUN, 60, 0, 0, 0, mk(PLAY, 0, 0, 1, 1, 0, 0, 0));
    add(K_TICK, 0, 1, 0, 0, mk(POINT, 1, 0, 0, 1, 1, 0, 1));
    add(K_RUN, 90, 0, 0, 0, mk(SERVE, 1, 1, 0, 1, 1, 0, 0));
    add(K_RUN, 60, 0, 0, 0, mk(PLAY, 0, 0, 0, 1, 1, 0, 0));
    add(K_TICK, 0, 1, 0, 0, mk(POINT, 1, 0, 0, 1, 2, 0, 1));
    add(K_RUN, 90, 0, 0, 0, mk(SERVE, 1, 1, 0, 1, 2, 0, 0));
    add(K_RUN, 60, 0, 0, 0, mk(PLAY, 0, 0, 0, 1, 2, 0, 0));
    add(K_TICK, 0, 1, 0, 0, mk(POINT, 1, 0, 0, 1, 3, 0, 1));
    add(K_RUN, 90, 0, 0, 0, mk(OVER, 1, 0, 0, 1, 3, 2, 0));
    add(K_TICK, 0, 1, 0, 0, mk(OVER, 1, 0, 0, 1, 3, 2, 0));
    add(K_TICK, 0, 0, 0, 1, mk(OVER, 1, 0, 0, 1, 3, 2, 0));
    add(K_START, 0, 0, 0, 0, mk(IDLE, 1, 0, 0, 1, 3, 2, 0));
    add(K_TICK, 0, 1, 0, 0, mk(IDLE, 1, 0, 0, 1, 3, 2, 0));
    add(K_START, 0, 0, 0, 0, mk(SERVE, 1, 1, 0, 0, 0, 0, 0));
    add(K_RUN, 60, 0, 0, 0, mk(PLAY, 0, 0, 0, 0, 0, 0, 0));
    add(K_TICK, 0, 0, 1, 0, mk(POINT, 1, 0, 1, 1, 0, 0, 1));
    add(K_RUN, 50, 0, 0, 0, mk(POINT, 1, 0, 1, 1, 0, 0, 0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    sb_q.push_back(mk(IDLE, 1, 0, 0, 0, 0, 0, 0));
    check("reset_values");
    reset = 1'b0;
    sb_q.push_back(mk(IDLE, 1, 0, 0, 0, 0, 0, 0));
    tick(0, 0, 0);
    check("idle_tick");
    sb_q.push_back(mk(IDLE, 1, 0, 0, 0, 0, 0, 0));
    press();
    check("start_latency_3");
    sb_q.push_back(mk(SERVE, 1, 1, 0, 0, 0, 0, 0));
    step();
    check("start_latency_4");
    sb_q.push_back(mk(SERVE, 1, 0, 0, 0, 0, 0, 0));
    step();
    check("recentre_single");
    cur = mk(SERVE, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      r = tbl[i];
      case (r.k)
        K_TICK: begin
          sb_q.push_back(r.e);
          tick(r.ml, r.mr, r.h);
          check($sformatf("row%0d_tick", i));
        end
        K_GAP: begin
          sb_q.push_back(r.e);
          gap(r.ml, r.mr, r.h);
          check($sformatf("row%0d_gap", i));
        end
        K_START: begin
          sb_q.push_back(r.e);
          press();
          step();
          check($sformatf("row%0d_start", i));
        end
        default: begin
          idle_e = cur;
          idle_e.rc = 1'b0;
          idle_e.bp = 1'b0;
          for (int j = 0; j < r.n - 1; j++) begin
            sb_q.push_back(idle_e);
            tick(0, 0, 0);
            check($sformatf("row%0d_run%0d", i, j));
          end
          sb_q.push_back(r.e);
          tick(0, 0, 0);
          check($sformatf("row%0d_run_end", i));
        end
      endcase
      cur = r.e;
    end
    // Forty frames remain in the point pause; reset must clear everything mid-cycle.
    reset = 1'b1;
    #1;
    sb_q.push_back(mk(IDLE, 1, 0, 0, 0, 0, 0, 0));
    check("reset_async_midpoint");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(mk(IDLE, 1, 0, 0, 0, 0, 0, 0));
      tick(1, 0, 1);
      check($sformatf("post_reset_tick%0d", i));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
